// File: rtl/des_iter_ctrl.sv
// -----------------------------------------------------------------------------
// des_iter_ctrl
//
// Sequencing controller for an iterative DES core. One 64-bit block is
// accepted per transaction. The controller then drives the shared datapath:
//   * a one-cycle load of IP(dat_in) into L/R and PC-1(key) into C/D;
//   * ROUNDS round commits, each lasting ROUND_CYCLES clocks, with the
//     key-schedule rotate amount and direction for that round;
//   * a result-valid phase held until the consumer takes the block.
// The controller owns no data bits. It only issues control and handshake
// signals.
//
// Parameters:
//   ROUNDS        number of Feistel rounds sequenced (1..16)
//   ROUND_CYCLES  clocks per round for a multicycle round function (1..8)
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   in_valid      request: dat_in and key on the datapath are valid
//   in_ready      controller can accept a request (decoded: high in IDLE)
//   decrypt       mode, sampled on accept (0 = encrypt, 1 = decrypt)
//   dp_load       load IP(dat_in) -> L/R and PC-1(key) -> C/D
//   dp_round_en   commit one round (shift C/D, then update L/R)
//   dp_round_idx  current round index, 0..ROUNDS-1
//   ks_shift      C/D rotate amount for this round (0, 1 or 2)
//   ks_dir        rotate direction (0 = left/encrypt, 1 = right/decrypt)
//   out_valid     FP(R16L16) on the datapath output is valid
//   out_ready     consumer accepts the result
//   busy          high in any state except IDLE
//   blk_cnt       count of completed output handshakes, wrapping
// -----------------------------------------------------------------------------
module des_iter_ctrl #(
  parameter int ROUNDS       = 16,
  parameter int ROUND_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        decrypt,
  output logic        dp_load,
  output logic        dp_round_en,
  output logic [3:0]  dp_round_idx,
  output logic [1:0]  ks_shift,
  output logic        ks_dir,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic [15:0] blk_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_DONE
  } state_e;

  localparam logic [3:0] LAST_RND = 4'(ROUNDS - 1);
  localparam logic [2:0] LAST_SUB = 3'(ROUND_CYCLES - 1);

  // Key-schedule rotate amount for round i.
  // Encryption rotates left before each round. Decryption walks the schedule
  // backwards: round 0 uses the unrotated C/D (the total rotation over 16
  // rounds is 28, a full turn), and each later round undoes an encrypt shift.
  function automatic logic [1:0] shift_for(input logic [3:0] idx, input logic dir);
    logic [1:0] amt;
    amt = 2'd2;
    if (!dir) begin
      if (idx == 4'd0 || idx == 4'd1 || idx == 4'd8 || idx == 4'd15) amt = 2'd1;
    end else begin
      if (idx == 4'd0) amt = 2'd0;
      else if (idx == 4'd1 || idx == 4'd8 || idx == 4'd15) amt = 2'd1;
    end
    return amt;
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  rnd_q, rnd_d;
  logic [2:0]  sub_q, sub_d;
  logic        mode_q, mode_d;
  logic [15:0] cnt_q, cnt_d;

  logic        load_q, load_d;
  logic        en_q, en_d;
  logic [3:0]  idx_q, idx_d;
  logic [1:0]  shift_q, shift_d;
  logic        dir_q, dir_d;
  logic        ov_q, ov_d;
  logic        busy_q, busy_d;
  logic        in_round_d;

  // Next state and counters.
  always_comb begin
    // NOTE: every variable gets a default before the case, so no path leaves
    // it unassigned and no latch is inferred.
    state_d = state_q;
    rnd_d   = rnd_q;
    sub_d   = sub_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        // in_ready is high here, so in_valid alone completes the accept.
        if (in_valid) begin
          state_d = S_LOAD;
          mode_d  = decrypt;
        end
      end
      S_LOAD: begin
        state_d = S_ROUND;
        rnd_d   = '0;
        sub_d   = '0;
      end
      S_ROUND: begin
        if (sub_q == LAST_SUB) begin
          sub_d = '0;
          if (rnd_q == LAST_RND) state_d = S_DONE;
          else                   rnd_d   = rnd_q + 4'd1;
        end else begin
          sub_d = sub_q + 3'd1;
        end
      end
      S_DONE: begin
        // No bypass to LOAD: a new request is accepted only after IDLE.
        if (out_ready) begin
          state_d = S_IDLE;
          cnt_d   = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state, so the registered copies line up
  // with the state they describe.
  always_comb begin
    in_round_d = (state_d == S_ROUND);
    load_d     = (state_d == S_LOAD);
    en_d       = in_round_d && (sub_d == LAST_SUB);
    idx_d      = in_round_d ? rnd_d : 4'd0;
    shift_d    = in_round_d ? shift_for(rnd_d, mode_d) : 2'd0;
    dir_d      = in_round_d && mode_d;
    ov_d       = (state_d == S_DONE);
    busy_d     = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rnd_q   <= '0;
      sub_q   <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      en_q    <= 1'b0;
      idx_q   <= '0;
      shift_q <= '0;
      dir_q   <= 1'b0;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      sub_q   <= sub_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      en_q    <= en_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      dir_q   <= dir_d;
      ov_q    <= ov_d;
      busy_q  <= busy_d;
    end
  end

  assign in_ready     = (state_q == S_IDLE);
  assign dp_load      = load_q;
  assign dp_round_en  = en_q;
  assign dp_round_idx = idx_q;
  assign ks_shift     = shift_q;
  assign ks_dir       = dir_q;
  assign out_valid    = ov_q;
  assign busy         = busy_q;
  assign blk_cnt      = cnt_q;

endmodule

// File: tb/tb_des_iter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_des_iter_ctrl
//
// Two controllers share one set of inputs: u_dut0 with ROUND_CYCLES=1 and
// u_dut1 with ROUND_CYCLES=3. A transaction-level reference model tracks,
// for each instance, whether a block is in flight and how many cycles have
// passed since its accept. Every expected output is derived from that
// elapsed time with plain arithmetic and the two shift tables.
// -----------------------------------------------------------------------------
module tb_des_iter_ctrl;

  localparam int ROUNDS = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic decrypt = 1'b0;
  logic out_ready = 1'b0;

  logic        in_ready_s [2];
  logic        load_s     [2];
  logic        en_s       [2];
  logic [3:0]  idx_s      [2];
  logic [1:0]  shift_s    [2];
  logic        dir_s      [2];
  logic        ov_s       [2];
  logic        busy_s     [2];
  logic [15:0] cnt_s      [2];

  always #5 clk = ~clk;

  des_iter_ctrl #(.ROUNDS(ROUNDS), .ROUND_CYCLES(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s[0]),
    .decrypt(decrypt), .dp_load(load_s[0]), .dp_round_en(en_s[0]),
    .dp_round_idx(idx_s[0]), .ks_shift(shift_s[0]), .ks_dir(dir_s[0]),
    .out_valid(ov_s[0]), .out_ready(out_ready), .busy(busy_s[0]),
    .blk_cnt(cnt_s[0])
  );

  des_iter_ctrl #(.ROUNDS(ROUNDS), .ROUND_CYCLES(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s[1]),
    .decrypt(decrypt), .dp_load(load_s[1]), .dp_round_en(en_s[1]),
    .dp_round_idx(idx_s[1]), .ks_shift(shift_s[1]), .ks_dir(dir_s[1]),
    .out_valid(ov_s[1]), .out_ready(out_ready), .busy(busy_s[1]),
    .blk_cnt(cnt_s[1])
  );

  // Key-schedule rotate amounts by round index.
  logic [1:0] enc_tbl [16] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                               2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
  logic [1:0] dec_tbl [16] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                               2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model state per instance.
  bit          m_busy [2];
  int          m_t    [2];   // cycles since accept while a block is in flight
  bit          m_mode [2];
  logic [15:0] m_cnt  [2];

  // Observed timing.
  logic rdy_prev [2];
  logic ov_prev  [2];
  int   acc_cyc  [2];
  int   lat      [2];
  bit   rec_acc = 1'b0;
  int   acc_q0 [$];
  int   acc_q1 [$];

  function automatic int rc_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int lat_of(input int k);
    return 2 + ROUNDS * rc_of(k);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 1'b0;
      m_t[k]    = 0;
      m_mode[k] = 1'b0;
      m_cnt[k]  = 16'd0;
    end
  endtask

  // Advance the model across one rising edge, using the inputs seen there.
  task automatic model_update(input int k);
    if (!rst_n) begin
      m_busy[k] = 1'b0;
      m_t[k]    = 0;
      m_mode[k] = 1'b0;
      m_cnt[k]  = 16'd0;
    end else if (!m_busy[k]) begin
      if (in_valid) begin
        m_busy[k] = 1'b1;
        m_t[k]    = 1;
        m_mode[k] = decrypt;
      end
    end else if (m_t[k] >= lat_of(k)) begin
      if (out_ready) begin
        m_busy[k] = 1'b0;
        m_t[k]    = 0;
        m_cnt[k]  = m_cnt[k] + 16'd1;
      end
    end else begin
      m_t[k] = m_t[k] + 1;
    end
  endtask

  task automatic compare(input int k);
    int         rc, p, idx;
    bit         in_rnd;
    logic [1:0] e_shift;
    rc      = rc_of(k);
    in_rnd  = m_busy[k] && m_t[k] >= 2 && m_t[k] < lat_of(k);
    p       = m_t[k] - 2;
    idx     = in_rnd ? p / rc : 0;
    e_shift = !in_rnd ? 2'd0 : (m_mode[k] ? dec_tbl[idx] : enc_tbl[idx]);
    check($sformatf("u%0d in_ready", k), in_ready_s[k], !m_busy[k]);
    check($sformatf("u%0d dp_load", k), load_s[k], m_busy[k] && m_t[k] == 1);
    check($sformatf("u%0d dp_round_en", k), en_s[k], in_rnd && (p % rc) == rc - 1);
    check($sformatf("u%0d dp_round_idx", k), idx_s[k], idx);
    check($sformatf("u%0d ks_shift", k), shift_s[k], e_shift);
    check($sformatf("u%0d ks_dir", k), dir_s[k], in_rnd && m_mode[k]);
    check($sformatf("u%0d out_valid", k), ov_s[k], m_busy[k] && m_t[k] >= lat_of(k));
    check($sformatf("u%0d busy", k), busy_s[k], m_busy[k]);
    check($sformatf("u%0d blk_cnt", k), cnt_s[k], m_cnt[k]);
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later.
  task automatic step();
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (rst_n && rdy_prev[k] && in_valid) begin
        acc_cyc[k] = cyc;
        if (rec_acc) begin
          if (k == 0) acc_q0.push_back(cyc);
          else        acc_q1.push_back(cyc);
        end
      end
      model_update(k);
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      compare(k);
      if (ov_s[k] && !ov_prev[k]) lat[k] = cyc - acc_cyc[k] + 1;
      ov_prev[k]  = ov_s[k];
      rdy_prev[k] = in_ready_s[k];
    end
  endtask

  task automatic drain();
    bit idle;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle      = 1'b0;
    for (int i = 0; i < 200 && !idle; i++) begin
      step();
      idle = !m_busy[0] && !m_busy[1];
    end
    check("drain reaches idle", idle, 1'b1);
  endtask

  task automatic wait_ov(input int k);
    bit seen;
    seen = ov_s[k];
    for (int i = 0; i < 120 && !seen; i++) begin
      step();
      seen = ov_s[k];
    end
    check($sformatf("u%0d out_valid arrives", k), seen, 1'b1);
  endtask

  typedef struct {
    logic        iv;
    logic        dec;
    logic        ordy;
    logic        e_rdy;
    logic        e_load;
    logic        e_en;
    logic [3:0]  e_idx;
    logic [1:0]  e_shift;
    logic        e_dir;
    logic        e_ov;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs [21];

  initial begin
    logic [15:0] cnt_before;
    int          ne, n3, nen1;

    // Encrypt block on u_dut0, one entry per cycle. in_valid/decrypt stay
    // high during the rounds and out_ready toggles: both must be ignored.
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 16'd0};
    for (int j = 1; j <= 16; j++)
      vecs[j] = '{1'b1, 1'b1, logic'(j % 2), 1'b0, 1'b0, 1'b1, 4'(j - 1), enc_tbl[j - 1],
                  1'b0, 1'b0, 16'd0};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b1, 16'd0};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b1, 16'd0};
    vecs[19] = vecs[18];
    vecs[20] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 16'd1};

    for (int k = 0; k < 2; k++) begin
      rdy_prev[k] = 1'b0;
      ov_prev[k]  = 1'b0;
      acc_cyc[k]  = 0;
      lat[k]      = 0;
    end
    model_reset();

    // Reset state.
    step();
    step();
    check("reset in_ready", in_ready_s[0], 1'b1);
    check("reset busy", busy_s[0], 1'b0);
    rst_n = 1'b1;
    step();

    // Test 1: table-driven encrypt block.
    for (int i = 0; i < 21; i++) begin
      in_valid  = vecs[i].iv;
      decrypt   = vecs[i].dec;
      out_ready = vecs[i].ordy;
      step();
      check($sformatf("vec%0d in_ready", i), in_ready_s[0], vecs[i].e_rdy);
      check($sformatf("vec%0d dp_load", i), load_s[0], vecs[i].e_load);
      check($sformatf("vec%0d dp_round_en", i), en_s[0], vecs[i].e_en);
      check($sformatf("vec%0d dp_round_idx", i), idx_s[0], vecs[i].e_idx);
      check($sformatf("vec%0d ks_shift", i), shift_s[0], vecs[i].e_shift);
      check($sformatf("vec%0d ks_dir", i), dir_s[0], vecs[i].e_dir);
      check($sformatf("vec%0d out_valid", i), ov_s[0], vecs[i].e_ov);
      check($sformatf("vec%0d blk_cnt", i), cnt_s[0], vecs[i].e_cnt);
    end
    check("t1 latency u0", lat[0], 18);
    drain();

    // Test 2: decrypt, with decrypt dropped straight after the accept.
    in_valid = 1'b1;
    decrypt  = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    decrypt  = 1'b0;
    ne = 0;
    for (int i = 0; i < 40 && !ov_s[0]; i++) begin
      step();
      if (en_s[0]) begin
        if (ne < 16) begin
          check($sformatf("dec idx r%0d", ne), idx_s[0], ne);
          check($sformatf("dec shift r%0d", ne), shift_s[0], dec_tbl[ne]);
          check($sformatf("dec dir r%0d", ne), dir_s[0], 1'b1);
        end
        ne++;
      end
    end
    check("dec round count", ne, 16);
    drain();

    // Test 3: backpressure for 10 cycles with in_valid pulses.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    decrypt   = 1'b0;
    step();
    in_valid = 1'b0;
    wait_ov(0);
    cnt_before = m_cnt[0];
    for (int i = 0; i < 10; i++) begin
      in_valid = logic'(i % 2);
      decrypt  = 1'b1;
      step();
      check("bp out_valid held", ov_s[0], 1'b1);
      check("bp in_ready low", in_ready_s[0], 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp out_valid drops", ov_s[0], 1'b0);
    check("bp blk_cnt +1", cnt_s[0], cnt_before + 16'd1);
    step();
    check("bp blk_cnt no extra", cnt_s[0], cnt_before + 16'd1);
    drain();

    // Test 4: ROUND_CYCLES=3 timing on u_dut1.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    n3   = 0;
    nen1 = 0;
    for (int i = 0; i < 120 && !ov_s[1]; i++) begin
      step();
      if (idx_s[1] == 4'd3) n3++;
      if (en_s[1]) nen1++;
    end
    check("rc3 latency u1", lat[1], 50);
    check("rc3 latency u0", lat[0], 18);
    check("rc3 idx3 hold cycles", n3, 3);
    check("rc3 enable count", nen1, 16);
    drain();

    // Test 5: reset at round index 7.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 40 && !(en_s[0] && idx_s[0] == 4'd7); i++) step();
    check("mid reset reached idx7", idx_s[0], 4'd7);
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst u%0d in_ready", k), in_ready_s[k], 1'b1);
      check($sformatf("rst u%0d dp_load", k), load_s[k], 1'b0);
      check($sformatf("rst u%0d dp_round_en", k), en_s[k], 1'b0);
      check($sformatf("rst u%0d dp_round_idx", k), idx_s[k], 4'd0);
      check($sformatf("rst u%0d ks_shift", k), shift_s[k], 2'd0);
      check($sformatf("rst u%0d ks_dir", k), dir_s[k], 1'b0);
      check($sformatf("rst u%0d out_valid", k), ov_s[k], 1'b0);
      check($sformatf("rst u%0d busy", k), busy_s[k], 1'b0);
      check($sformatf("rst u%0d blk_cnt", k), cnt_s[k], 16'd0);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    in_valid = 1'b1;
    step();
    drain();
    check("post reset completion", cnt_s[0], 16'd1);

    // Test 6: counter wrap, preloading u_dut0's counter to 0xFFFF.
    force u_dut0.cnt_q = 16'hFFFF;
    m_cnt[0] = 16'hFFFF;
    out_ready = 1'b0;
    step();
    release u_dut0.cnt_q;
    step();
    check("wrap preload", cnt_s[0], 16'hFFFF);
    in_valid = 1'b1;
    step();
    drain();
    check("wrap to zero", cnt_s[0], 16'h0000);

    // Back-to-back throughput with out_ready held high.
    rec_acc   = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 130; i++) step();
    rec_acc = 1'b0;
    drain();
    check("b2b u0 accepts", acc_q0.size() >= 4, 1'b1);
    check("b2b u1 accepts", acc_q1.size() >= 2, 1'b1);
    for (int i = 1; i < acc_q0.size(); i++)
      check($sformatf("b2b u0 spacing %0d", i), acc_q0[i] - acc_q0[i - 1], 19);
    for (int i = 1; i < acc_q1.size(); i++)
      check($sformatf("b2b u1 spacing %0d", i), acc_q1[i] - acc_q1[i - 1], 51);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) == 0);
      decrypt   = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 1) == 1;
      step();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (checks %0d, errors %0d)",
             n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
